pattern_sched: RTL and testbench

PATTERN_SCHED -- requirements
Module: pattern_sched

---
 rtl/pattern_sched_pkg.sv | 19 +
 rtl/pattern_step_gen.sv | 31 +++
 rtl/pattern_sched.sv | 111 +++++++++++
 tb/tb_pattern_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sched_pkg.sv
// Shared types and constants for the pattern burst scheduler.
package pattern_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int LEN_W_DEF = 4;

  // Beat values packed low-index-first: 1, 9, 3, 5
  localparam logic [15:0] PATTERN = {4'd5, 4'd3, 4'd9, 4'd1};

  function automatic logic [3:0] pattern_at(input logic [1:0] i);
    return PATTERN[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/pattern_step_gen.sv
// Steps through the pattern table; value is registered and zero whenever no beat is emitted.
module pattern_step_gen
  import pattern_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  output logic [1:0] idx,
  output logic [3:0] value
);

  logic [1:0] idx_nxt;

  // clear with enable starts a burst at entry 0; enable alone advances
  assign idx_nxt = clear ? 2'd0 : idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 2'd0;
      value <= 4'd0;
    end else if (enable) begin
      idx   <= idx_nxt;
      value <= pattern_at(idx_nxt);
    end else begin
      idx   <= 2'd0;
      value <= 4'd0;
    end
  end

endmodule

// File: rtl/pattern_sched.sv
// Round-robin scheduler granting pattern bursts of 1..2**LEN_W beats to requester A or B.
module pattern_sched
  import pattern_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [LEN_W-1:0] len_a,
  input  logic             req_b,
  input  logic [LEN_W-1:0] len_b,
  input  logic             abort,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [3:0]       q,
  output logic             q_valid,
  output logic             done_a,
  output logic             done_b,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             last_b;
  logic             pick_a;
  logic             start;
  logic             cont;
  logic             last_beat;
  logic [1:0]       step_idx;

  assign pick_a    = req_a && (!req_b || last_b);
  assign start     = (state == ST_IDLE) && (req_a || req_b);
  // len 0 wraps to all-ones here, giving the full 2**LEN_W beats
  assign last_beat = (cnt == len_q - LEN_ONE);
  assign cont      = (state == ST_RUN) && !abort && !last_beat;

  pattern_step_gen u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (start || cont),
    .clear  (!cont),
    .idx    (step_idx),
    .value  (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      q_valid <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      busy    <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
      last_b  <= 1'b1;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            gnt_a   <= pick_a;
            gnt_b   <= !pick_a;
            len_q   <= pick_a ? len_a : len_b;
            cnt     <= '0;
            q_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state   <= ST_IDLE;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
            last_b  <= gnt_b;
          end else if (last_beat) begin
            state   <= ST_DONE;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            q_valid <= 1'b0;
            done_a  <= gnt_a;
            done_b  <= gnt_b;
            last_b  <= gnt_b;
          end else begin
            cnt <= cnt + LEN_ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
  a_vld_owner: assert property (@(posedge clk) disable iff (!rst_n) q_valid |-> (gnt_a ^ gnt_b));
  a_q_table: assert property (@(posedge clk) disable iff (!rst_n)
    q == (q_valid ? pattern_at(step_idx) : 4'd0));

endmodule

// File: tb/tb_pattern_sched.sv
// Bench for pattern_sched: vector table plus hand sequences, beats checked via scoreboard queue.
module tb_pattern_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic [3:0] len_a = 4'd0;
  logic       req_b = 1'b0;
  logic [3:0] len_b = 4'd0;
  logic       abort = 1'b0;
  logic       gnt_a, gnt_b, q_valid, done_a, done_b, busy;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         a;
    logic [3:0] q;
    bit         done_next;
  } beat_t;

  typedef struct {
    bit         ra;
    bit         rb;
    logic [3:0] la;
    logic [3:0] lb;
    int         abort_beat;
    bit         exp_a;
  } vec_t;

  beat_t sb[$];
  int    pat[4] = '{1, 9, 3, 5};
  bit    exp_done_a = 1'b0;
  bit    exp_done_b = 1'b0;
  vec_t  vecs[9];

  pattern_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .len_a   (len_a),
    .req_b   (req_b),
    .len_b   (len_b),
    .abort   (abort),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .q       (q),
    .q_valid (q_valid),
    .done_a  (done_a),
    .done_b  (done_b),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input bit a, input int n, input bit aborted);
    for (int k = 0; k < n; k++)
      sb.push_back('{a: a, q: 4'(pat[k % 4]), done_next: (k == n - 1) && !aborted});
  endtask

  // Monitor: every beat is popped from the scoreboard, done pulses must follow a final beat
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst_n) begin
      exp_done_a = 1'b0;
      exp_done_b = 1'b0;
    end else begin
      chk("done_a", int'(done_a), int'(exp_done_a));
      chk("done_b", int'(done_b), int'(exp_done_b));
      exp_done_a = 1'b0;
      exp_done_b = 1'b0;
      chk("gnt_excl", int'(gnt_a & gnt_b), 0);
      if (q_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", int'(q), -1);
        end else begin
          e = sb.pop_front();
          chk("beat_q", int'(q), int'(e.q));
          chk("beat_gnt_a", int'(gnt_a), int'(e.a));
          chk("beat_gnt_b", int'(gnt_b), int'(!e.a));
          if (e.done_next) begin
            exp_done_a = e.a;
            exp_done_b = !e.a;
          end
        end
      end else begin
        chk("idle_q", int'(q), 0);
        chk("idle_gnt", int'({gnt_a, gnt_b}), 0);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, int'(busy), 0);
    @(negedge clk);
    chk({name, "_sb_drain"}, sb.size(), 0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int    len, nb, n, beats;
    bit    aborted;
    string nm;
    nm      = $sformatf("vec%0d", id);
    len     = v.exp_a ? int'(v.la) : int'(v.lb);
    if (len == 0) len = 16;
    aborted = v.abort_beat > 0;
    nb      = aborted ? v.abort_beat : len;
    push_burst(v.exp_a, nb, aborted);
    @(negedge clk);
    req_a = v.ra; len_a = v.la;
    req_b = v.rb; len_b = v.lb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt_a || gnt_b) && n < 10);
    chk({nm, "_grant_latency"}, n, 1);
    req_a = 1'b0; req_b = 1'b0;
    len_a = 4'hA; len_b = 4'hA;
    if (aborted) begin
      beats = 1;
      while (beats < v.abort_beat) begin
        @(negedge clk);
        beats++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({nm, "_abort_drop"}, int'({gnt_a, gnt_b, q_valid, busy}), 0);
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ra: 1, rb: 0, la: 4'd5,  lb: 4'd0, abort_beat: 0, exp_a: 1};
    vecs[1] = '{ra: 0, rb: 1, la: 4'd0,  lb: 4'd0, abort_beat: 0, exp_a: 0};
    vecs[2] = '{ra: 1, rb: 1, la: 4'd3,  lb: 4'd7, abort_beat: 0, exp_a: 1};
    vecs[3] = '{ra: 1, rb: 1, la: 4'd2,  lb: 4'd4, abort_beat: 0, exp_a: 0};
    vecs[4] = '{ra: 1, rb: 0, la: 4'd6,  lb: 4'd0, abort_beat: 3, exp_a: 1};
    vecs[5] = '{ra: 1, rb: 1, la: 4'd1,  lb: 4'd2, abort_beat: 0, exp_a: 0};
    vecs[6] = '{ra: 0, rb: 1, la: 4'd0,  lb: 4'd1, abort_beat: 0, exp_a: 0};
    vecs[7] = '{ra: 1, rb: 1, la: 4'd4,  lb: 4'd4, abort_beat: 4, exp_a: 1};
    vecs[8] = '{ra: 1, rb: 0, la: 4'd15, lb: 4'd0, abort_beat: 0, exp_a: 1};

    // Reset state with a request already pending
    req_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({gnt_a, gnt_b, q, q_valid, done_a, done_b, busy}), 0);
    req_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesting from reset: A, then B after a two-cycle gap, then A again; abort in IDLE ignored
    push_burst(1'b1, 2, 1'b0);
    push_burst(1'b0, 2, 1'b0);
    push_burst(1'b1, 2, 1'b0);
    req_a = 1'b1; len_a = 4'd2;
    req_b = 1'b1; len_b = 4'd2;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("rr_first_gnt_a", int'(gnt_a), 1);
    @(negedge clk);
    @(negedge clk);
    chk("rr_done_cycle", int'({busy, q_valid}), 2);
    @(negedge clk);
    chk("rr_gap_idle", int'({busy, q_valid}), 0);
    @(negedge clk);
    chk("rr_second_gnt_b", int'({gnt_a, gnt_b, q_valid}), 3);
    repeat (4) @(negedge clk);
    chk("rr_third_gnt_a", int'({gnt_a, gnt_b}), 2);
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("rr");

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset during beat 2 of a B burst, then A must win against B from the reset pointer
    push_burst(1'b0, 2, 1'b1);
    @(negedge clk);
    req_b = 1'b1; len_b = 4'd8;
    @(negedge clk);
    req_b = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", int'({gnt_a, gnt_b, q, q_valid, done_a, done_b, busy}), 0);
    @(negedge clk);
    chk("reset_sb_drain", sb.size(), 0);
    push_burst(1'b1, 2, 1'b0);
    req_a = 1'b1; len_a = 4'd2;
    req_b = 1'b1; len_b = 4'd2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_gnt_a", int'({gnt_a, gnt_b, q}), 'b10_0001);
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
